// File: rtl/deser_queue_top.sv
// Serial receive path: MSB-first deserializer feeding an 8-entry byte queue.
// Define DESER_LSB_FIRST_EN to shift bits in LSB-first instead.
module deser_queue_top #(
    parameter int DATA_WIDTH  = 8,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  write_in,
    input  logic                  enqueue_in,
    input  logic                  dequeue_in,
    output logic                  data_ready,
    output logic                  status_out,
    output logic [3:0]            len_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(QUEUE_DEPTH - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [3:0]    DEPTH_L  = 4'(QUEUE_DEPTH);

    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CW-1:0]         r_cnt;
    logic                  r_ready;
    logic                  r_status;
    logic [3:0]            r_len;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [DATA_WIDTH-1:0] r_mem [QUEUE_DEPTH];

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_shreg_next;

    assign w_accept = write_in & r_status;
    // Full check uses the registered length, so a same-edge pop never frees room for a push.
    assign w_push   = r_ready & enqueue_in & (r_len < DEPTH_L);
    assign w_pop    = dequeue_in & (r_len != 4'd0);

`ifdef DESER_LSB_FIRST_EN
    assign w_shreg_next = {data_in, r_shreg[DATA_WIDTH-1:1]};
`else
    assign w_shreg_next = {r_shreg[DATA_WIDTH-2:0], data_in};
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_status <= 1'b1;
            r_len    <= 4'd0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_dout   <= '0;
        end else begin
            if (w_accept) begin
                r_shreg <= w_shreg_next;
                if (r_cnt == LAST_BIT) begin
                    r_cnt    <= '0;
                    r_ready  <= 1'b1;
                    r_status <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_push) begin
                r_ready  <= 1'b0;
                r_status <= 1'b1;
            end

            if (w_push)
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;

            if (w_pop) begin
                r_dout <= r_mem[r_rptr];
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_len <= r_len + 4'd1;
                2'b01:   r_len <= r_len - 4'd1;
                default: r_len <= r_len;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset && w_push)
            r_mem[r_wptr] <= r_shreg;
    end

    assign data_ready = r_ready;
    assign status_out = r_status;
    assign len_out    = r_len;
    assign data_out   = r_dout;

endmodule

// File: tb/tb_deser_queue_top.sv
// Randomized and directed bench for deser_queue_top against a queue-level reference model.
module tb_deser_queue_top;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       data_in = 1'b0;
    logic       write_in = 1'b0;
    logic       enqueue_in = 1'b0;
    logic       dequeue_in = 1'b0;
    logic       data_ready;
    logic       status_out;
    logic [3:0] len_out;
    logic [7:0] data_out;

    int n_checks = 0;
    int n_errors = 0;

    deser_queue_top #(.DATA_WIDTH(8), .QUEUE_DEPTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .write_in   (write_in),
        .enqueue_in (enqueue_in),
        .dequeue_in (dequeue_in),
        .data_ready (data_ready),
        .status_out (status_out),
        .len_out    (len_out),
        .data_out   (data_out)
    );

    always #5 clock = ~clock;

    // Reference model: a byte list plus a pending-byte flag and bit accumulator
    int   m_q[$];
    bit   m_valid   = 1'b0;
    bit   m_pending = 1'b0;
    int   m_pbyte   = 0;
    int   m_acc     = 0;
    int   m_nbits   = 0;
    int   m_dout    = 0;

    always @(posedge clock) begin
        if (!reset) begin
            m_valid   = 1'b1;
            m_q.delete();
            m_pending = 1'b0;
            m_pbyte   = 0;
            m_acc     = 0;
            m_nbits   = 0;
            m_dout    = 0;
        end else begin
            bit do_push, do_pop;
            do_push = m_pending && enqueue_in && (m_q.size() < 8);
            do_pop  = dequeue_in && (m_q.size() > 0);
            if (do_pop) m_dout = m_q.pop_front();
            if (do_push) begin
                m_q.push_back(m_pbyte);
                m_pending = 1'b0;
            end else if (!m_pending && write_in) begin
`ifdef DESER_LSB_FIRST_EN
                m_acc = m_acc | (int'(data_in) << m_nbits);
`else
                m_acc = m_acc * 2 + int'(data_in);
`endif
                m_nbits++;
                if (m_nbits == 8) begin
                    m_pending = 1'b1;
                    m_pbyte   = m_acc;
                    m_acc     = 0;
                    m_nbits   = 0;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_valid) begin
            check("data_ready", int'(data_ready), int'(m_pending));
            check("status_out", int'(status_out), int'(!m_pending));
            check("len_out",    int'(len_out),    m_q.size());
            check("data_out",   int'(data_out),   m_dout);
        end
    end

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            if (gaps) begin
                write_in = 1'b0;
                data_in  = ~b[i];
                cyc();
            end
            write_in = 1'b1;
            data_in  = b[i];
            cyc();
        end
        write_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic drain();
        dequeue_in = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        dequeue_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp01;
        int seen_ready;
`ifdef DESER_LSB_FIRST_EN
        exp01 = 8'h80;
`else
        exp01 = 8'h01;
`endif
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        check("rst_len",    int'(len_out), 0);
        check("rst_dout",   int'(data_out), 0);
        check("rst_ready",  int'(data_ready), 0);
        check("rst_status", int'(status_out), 1);

        // 0xA5 with enqueue enabled
        enqueue_in = 1'b1;
        send_bits(8'hA5, 1'b0);
        check("a5_ready", int'(data_ready), 1);
        cyc();
        check("a5_len1", int'(len_out), 1);
        check("a5_ready_pulse", int'(data_ready), 0);
        dequeue_in = 1'b1;
        cyc();
        dequeue_in = 1'b0;
        check("a5_dout", int'(data_out), 8'hA5);
        check("a5_len0", int'(len_out), 0);

        send_bits(8'h01, 1'b0);
        cyc();
        dequeue_in = 1'b1;
        cyc();
        dequeue_in = 1'b0;
        check("b01_dout", int'(data_out), int'(exp01));

        // Gapped strobes: ready appears only after the 8th accepted bit
        seen_ready = 0;
        for (int i = 7; i >= 0; i--) begin
            write_in = 1'b0;
            cyc();
            seen_ready += int'(data_ready);
            write_in = 1'b1;
            data_in  = 8'hA5 >> i;
            cyc();
        end
        write_in = 1'b0;
        check("gap_no_early_ready", seen_ready, 0);
        check("gap_ready", int'(data_ready), 1);
        cyc();
        dequeue_in = 1'b1;
        cyc();
        dequeue_in = 1'b0;
        check("gap_dout", int'(data_out), 8'hA5);

        // Hold with enqueue off; extra bits must be ignored
        enqueue_in = 1'b0;
        send_bits(8'h3C, 1'b0);
        send_bits(8'hFF, 1'b0);
        check("hold_ready", int'(data_ready), 1);
        check("hold_status", int'(status_out), 0);
        enqueue_in = 1'b1;
        cyc();
        check("hold_len", int'(len_out), 1);
        check("hold_status1", int'(status_out), 1);
        drain();

        // Nine bytes into an 8-deep queue, then pop through the wrap
        for (int k = 1; k <= 9; k++) begin
            send_bits(8'(k), 1'b0);
            cyc();
        end
        check("full_len", int'(len_out), 8);
        check("full_pending", int'(data_ready), 1);
        dequeue_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check("full_pop_seq", int'(data_out), k);
        end
        dequeue_in = 1'b0;
        check("ninth_len", int'(len_out), 1);
        drain();

        // Pop on empty
        dequeue_in = 1'b1;
        cyc();
        dequeue_in = 1'b0;
        check("empty_len", int'(len_out), 0);
        check("empty_dout", int'(data_out), 9);

        // Randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            write_in   = 1'($urandom_range(0, 3) != 0);
            data_in    = 1'($urandom);
            enqueue_in = 1'($urandom_range(0, 2) != 0);
            dequeue_in = 1'($urandom_range(0, 3) == 0);
            reset      = 1'($urandom_range(0, 299) != 0);
            cyc();
        end
        reset = 1'b1;
        write_in = 1'b0;
        dequeue_in = 1'b0;
        drain();

        // Reset with three queued bytes and a half byte in flight
        enqueue_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_bits(8'h50 + 8'(k), 1'b0);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            write_in = 1'b1;
            data_in  = 1'b1;
            cyc();
        end
        write_in = 1'b0;
        check("pre_rst_len", int'(len_out), 3);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("mid_rst_len",    int'(len_out), 0);
        check("mid_rst_dout",   int'(data_out), 0);
        check("mid_rst_ready",  int'(data_ready), 0);
        check("mid_rst_status", int'(status_out), 1);
        send_bits(8'hC3, 1'b0);
        cyc();
        dequeue_in = 1'b1;
        cyc();
        dequeue_in = 1'b0;
        cyc();
`ifdef DESER_LSB_FIRST_EN
        check("post_rst_dout", int'(data_out), 8'hC3);
`else
        check("post_rst_dout", int'(data_out), 8'hC3);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
